// File: rtl/cdb_broadcaster_if.sv
// Common data bus interface: result offers from the functional units on one
// side, the registered broadcast triple (plus debug/error flags) on the other.
// master = broadcaster side, slave = functional-unit / consumer side.
interface cdb_broadcaster_if #(
    parameter int N_SRC   = 3,
    parameter int LABEL_W = 4,
    parameter int DATA_W  = 32
);
    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0]         src_valid;
    logic [N_SRC*LABEL_W-1:0] src_label;
    logic [N_SRC*DATA_W-1:0]  src_data;
    logic [N_SRC-1:0]         src_ready;
    logic                     BCEN;
    logic [LABEL_W-1:0]       BClabel;
    logic [DATA_W-1:0]        BCdata;
    logic [SRC_W-1:0]         BCsrc;
    logic                     drop_err;

    modport master (
        input  src_valid, src_label, src_data,
        output src_ready, BCEN, BClabel, BCdata, BCsrc, drop_err
    );

    modport slave (
        output src_valid, src_label, src_data,
        input  src_ready, BCEN, BClabel, BCdata, BCsrc, drop_err
    );
endinterface

// File: rtl/cdb_broadcaster.sv
// Transmitting end of the common data bus. Each functional unit feeds a small
// FIFO; a round-robin arbiter picks one non-empty head per cycle and the winner
// is registered onto BCEN/BClabel/BCdata/BCsrc. Label 0 means "no tag": such
// results are accepted, thrown away, and flagged on the sticky drop_err.
module cdb_broadcaster #(
    parameter int N_SRC   = 3,
    parameter int DEPTH   = 2,
    parameter int LABEL_W = 4,
    parameter int DATA_W  = 32
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             flush,
    cdb_broadcaster_if.master bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(N_SRC - 1);
    localparam logic [SRC_W:0]   NSRC_EXT = (SRC_W + 1)'(N_SRC);

    // Per-source status and handshake qualifiers
    logic [N_SRC-1:0]   w_empty;
    logic [N_SRC-1:0]   w_full;
    logic [N_SRC-1:0]   w_accept;
    logic [N_SRC-1:0]   w_push;
    logic [N_SRC-1:0]   w_pop;
    logic [N_SRC-1:0]   w_drop;
    logic [LABEL_W-1:0] w_head_label [N_SRC];
    logic [DATA_W-1:0]  w_head_data  [N_SRC];

    // Arbitration
    logic               w_any;
    logic [SRC_W-1:0]   w_winner;
    logic [SRC_W:0]     w_sum;
    logic [SRC_W-1:0]   r_rr_ptr;

    // Broadcast register
    logic               r_bcen;
    logic [LABEL_W-1:0] r_bclabel;
    logic [DATA_W-1:0]  r_bcdata;
    logic [SRC_W-1:0]   r_bcsrc;
    logic               r_drop_err;

    // Ready depends only on occupancy: a full FIFO refuses even when it pops
    // in the same cycle, which keeps src_ready off the arbitration path.
    assign w_accept      = bus.src_valid & ~w_full;
    assign bus.src_ready = ~w_full;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            logic [LABEL_W-1:0] w_label;
            logic [DATA_W-1:0]  w_data;
            logic [LABEL_W-1:0] r_mem_label [DEPTH];
            logic [DATA_W-1:0]  r_mem_data  [DEPTH];
            logic [PTR_W-1:0]   r_wr_ptr;
            logic [PTR_W-1:0]   r_rd_ptr;
            logic [CNT_W-1:0]   r_count;

            assign w_label = bus.src_label[gi*LABEL_W +: LABEL_W];
            assign w_data  = bus.src_data[gi*DATA_W +: DATA_W];

            // Label-0 offers complete the handshake but never enter the FIFO;
            // a flush discards whatever is offered in the same cycle.
            assign w_drop[gi] = w_accept[gi] && (w_label == '0);
            assign w_push[gi] = w_accept[gi] && (w_label != '0) && !flush;
            assign w_pop[gi]  = w_any && (w_winner == SRC_W'(gi)) && !flush;

            assign w_empty[gi] = (r_count == '0);
            assign w_full[gi]  = (r_count == FULL_CNT);

            // Heads are read combinationally so the arbiter can pick this cycle
            assign w_head_label[gi] = r_mem_label[r_rd_ptr];
            assign w_head_data[gi]  = r_mem_data[r_rd_ptr];

            // FIFO storage write (no reset needed: validity comes from r_count)
            always_ff @(posedge clk) begin
                if (w_push[gi]) begin
                    r_mem_label[r_wr_ptr] <= w_label;
                    r_mem_data[r_wr_ptr]  <= w_data;
                end
            end

            // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
            always_ff @(posedge clk or posedge RST) begin
                if (RST) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else if (flush) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push[gi]) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                    if (w_pop[gi]) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                    case ({w_push[gi], w_pop[gi]})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
            end
        end
    endgenerate

    // Round-robin pick: scan from r_rr_ptr upward with wrap. Walking the
    // offsets from farthest to nearest lets the nearest non-empty source win.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (SRC_W + 1)'(k);
            if (w_sum >= NSRC_EXT) begin
                w_sum = w_sum - NSRC_EXT;
            end
            if (!w_empty[w_sum[SRC_W-1:0]]) begin
                w_any    = 1'b1;
                w_winner = w_sum[SRC_W-1:0];
            end
        end
    end

    // Round-robin pointer moves just past the winner; idle cycles leave it alone
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_rr_ptr <= '0;
        end else if (flush) begin
            r_rr_ptr <= '0;
        end else if (w_any) begin
            r_rr_ptr <= (w_winner == LAST_SRC) ? '0 : w_winner + 1'b1;
        end
    end

    // Broadcast register: BCEN pulses once per popped result; the payload
    // holds on idle cycles since consumers qualify it with BCEN.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_bcen    <= 1'b0;
            r_bclabel <= '0;
            r_bcdata  <= '0;
            r_bcsrc   <= '0;
        end else if (flush) begin
            r_bcen <= 1'b0;
        end else begin
            r_bcen <= w_any;
            if (w_any) begin
                r_bclabel <= w_head_label[w_winner];
                r_bcdata  <= w_head_data[w_winner];
                r_bcsrc   <= w_winner;
            end
        end
    end

    // Sticky flag for discarded label-0 results; only reset clears it
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_drop_err <= 1'b0;
        end else if (|w_drop) begin
            r_drop_err <= 1'b1;
        end
    end

    assign bus.BCEN     = r_bcen;
    assign bus.BClabel  = r_bclabel;
    assign bus.BCdata   = r_bcdata;
    assign bus.BCsrc    = r_bcsrc;
    assign bus.drop_err = r_drop_err;
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed bench for cdb_broadcaster: reset, single result latency, three-way
// contention, backpressure, label-0 drop, flush and reset mid-broadcast.
module tb_cdb_broadcaster;
    localparam int N_SRC   = 3;
    localparam int DEPTH   = 2;
    localparam int LABEL_W = 4;
    localparam int DATA_W  = 32;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    cdb_broadcaster_if #(.N_SRC(N_SRC), .LABEL_W(LABEL_W), .DATA_W(DATA_W)) bus ();

    cdb_broadcaster #(
        .N_SRC  (N_SRC),
        .DEPTH  (DEPTH),
        .LABEL_W(LABEL_W),
        .DATA_W (DATA_W)
    ) u_dut (
        .clk  (clk),
        .RST  (rst),
        .flush(flush),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Check one broadcast slot; payload only matters when BCEN is expected high
    task automatic chk_bc(input string tag, input logic en, input logic [3:0] lab,
                          input logic [31:0] dat, input logic [1:0] src);
        $display("%0t %s: BCEN=%0b BClabel=%0d BCdata=0x%0h BCsrc=%0d",
                 $time, tag, bus.BCEN, bus.BClabel, bus.BCdata, bus.BCsrc);
        chk({tag, ".BCEN"}, {31'd0, bus.BCEN}, {31'd0, en});
        if (en) begin
            chk({tag, ".BClabel"}, {28'd0, bus.BClabel}, {28'd0, lab});
            chk({tag, ".BCdata"}, bus.BCdata, dat);
            chk({tag, ".BCsrc"}, {30'd0, bus.BCsrc}, {30'd0, src});
        end
    endtask

    task automatic offer(input int s, input logic [3:0] lab, input logic [31:0] dat);
        bus.src_valid[s] = 1'b1;
        bus.src_label[s*LABEL_W +: LABEL_W] = lab;
        bus.src_data[s*DATA_W +: DATA_W]    = dat;
    endtask

    task automatic idle(input int s);
        bus.src_valid[s] = 1'b0;
    endtask

    initial begin
        // ---- 1: reset with offers present ----
        bus.src_valid = 3'b111;
        bus.src_label = {4'd3, 4'd2, 4'd1};
        bus.src_data  = '1;
        tick();
        tick();
        chk_bc("rst_hold", 1'b0, 4'd0, 32'd0, 2'd0);
        chk("rst_hold.BClabel", {28'd0, bus.BClabel}, 32'd0);
        chk("rst_hold.BCdata", bus.BCdata, 32'd0);
        chk("rst_hold.BCsrc", {30'd0, bus.BCsrc}, 32'd0);
        chk("rst_hold.drop_err", {31'd0, bus.drop_err}, 32'd0);
        bus.src_valid = 3'b000;
        rst = 1'b0;
        tick();
        chk("rst_rel.src_ready", {29'd0, bus.src_ready}, 32'd7);
        chk_bc("rst_rel", 1'b0, 4'd0, 32'd0, 2'd0);

        // ---- 2: single result, two-cycle latency ----
        offer(0, 4'd5, 32'hDEADBEEF);
        tick();
        idle(0);
        chk_bc("single_e0", 1'b0, 4'd0, 32'd0, 2'd0);
        tick();
        chk_bc("single_e1", 1'b1, 4'd5, 32'hDEADBEEF, 2'd0);
        tick();
        chk_bc("single_e2", 1'b0, 4'd0, 32'd0, 2'd0);

        // Empty flush returns the round-robin pointer to source 0
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_bc("flush_idle", 1'b0, 4'd0, 32'd0, 2'd0);

        // ---- 3: contention from rr_ptr = 0 ----
        offer(0, 4'd1, 32'h100);
        offer(1, 4'd2, 32'h200);
        offer(2, 4'd3, 32'h300);
        tick();
        idle(0); idle(1); idle(2);
        tick();
        chk_bc("cont_a0", 1'b1, 4'd1, 32'h100, 2'd0);
        tick();
        chk_bc("cont_a1", 1'b1, 4'd2, 32'h200, 2'd1);
        tick();
        chk_bc("cont_a2", 1'b1, 4'd3, 32'h300, 2'd2);
        tick();
        chk_bc("cont_a3", 1'b0, 4'd0, 32'd0, 2'd0);
        offer(0, 4'd10, 32'hA0A);
        offer(1, 4'd11, 32'hB0B);
        offer(2, 4'd12, 32'hC0C);
        tick();
        idle(0); idle(1); idle(2);
        tick();
        chk_bc("cont_b0", 1'b1, 4'd10, 32'hA0A, 2'd0);
        tick();
        chk_bc("cont_b1", 1'b1, 4'd11, 32'hB0B, 2'd1);
        tick();
        chk_bc("cont_b2", 1'b1, 4'd12, 32'hC0C, 2'd2);
        tick();
        chk_bc("cont_b3", 1'b0, 4'd0, 32'd0, 2'd0);

        // ---- 4: backpressure on src1 while src0 competes ----
        offer(0, 4'd13, 32'h1313);
        offer(1, 4'd4, 32'h44);
        tick();
        chk_bc("bp_e1", 1'b0, 4'd0, 32'd0, 2'd0);
        offer(0, 4'd14, 32'h1414);
        offer(1, 4'd5, 32'h55);
        tick();
        chk_bc("bp_e2", 1'b1, 4'd13, 32'h1313, 2'd0);
        chk("bp_e2.ready1", {31'd0, bus.src_ready[1]}, 32'd0);
        offer(0, 4'd15, 32'h1515);
        offer(1, 4'd6, 32'h66);
        tick();
        chk_bc("bp_e3", 1'b1, 4'd4, 32'h44, 2'd1);
        chk("bp_e3.ready1", {31'd0, bus.src_ready[1]}, 32'd1);
        chk("bp_e3.ready0", {31'd0, bus.src_ready[0]}, 32'd0);
        idle(0);
        tick();
        idle(1);
        chk_bc("bp_e4", 1'b1, 4'd14, 32'h1414, 2'd0);
        tick();
        chk_bc("bp_e5", 1'b1, 4'd5, 32'h55, 2'd1);
        tick();
        chk_bc("bp_e6", 1'b1, 4'd15, 32'h1515, 2'd0);
        tick();
        chk_bc("bp_e7", 1'b1, 4'd6, 32'h66, 2'd1);
        tick();
        chk_bc("bp_e8", 1'b0, 4'd0, 32'd0, 2'd0);

        // ---- 5: label 0 is accepted, dropped and flagged ----
        offer(2, 4'd0, 32'd7);
        chk("lbl0.ready2", {31'd0, bus.src_ready[2]}, 32'd1);
        tick();
        idle(2);
        chk("lbl0.drop_err", {31'd0, bus.drop_err}, 32'd1);
        chk_bc("lbl0_e0", 1'b0, 4'd0, 32'd0, 2'd0);
        tick();
        chk_bc("lbl0_e1", 1'b0, 4'd0, 32'd0, 2'd0);
        tick();
        chk_bc("lbl0_e2", 1'b0, 4'd0, 32'd0, 2'd0);
        chk("lbl0.sticky", {31'd0, bus.drop_err}, 32'd1);

        // ---- 6: flush with four results buffered ----
        offer(0, 4'd1, 32'h11);
        offer(1, 4'd2, 32'h22);
        offer(2, 4'd3, 32'h33);
        tick();
        idle(2);
        offer(0, 4'd4, 32'h44);
        offer(1, 4'd5, 32'h55);
        tick();
        idle(0); idle(1);
        chk_bc("fl_pre", 1'b1, 4'd3, 32'h33, 2'd2);
        flush = 1'b1;
        offer(2, 4'd11, 32'hBB);
        tick();
        flush = 1'b0;
        idle(2);
        chk_bc("fl_e0", 1'b0, 4'd0, 32'd0, 2'd0);
        tick();
        chk_bc("fl_e1", 1'b0, 4'd0, 32'd0, 2'd0);
        tick();
        chk_bc("fl_e2", 1'b0, 4'd0, 32'd0, 2'd0);
        chk("fl.src_ready", {29'd0, bus.src_ready}, 32'd7);
        chk("fl.drop_err", {31'd0, bus.drop_err}, 32'd1);
        offer(1, 4'd9, 32'h99);
        tick();
        idle(1);
        chk_bc("fl_new0", 1'b0, 4'd0, 32'd0, 2'd0);
        tick();
        chk_bc("fl_new1", 1'b1, 4'd9, 32'h99, 2'd1);
        tick();
        chk_bc("fl_new2", 1'b0, 4'd0, 32'd0, 2'd0);

        // ---- reset mid-broadcast: BCEN drops at once, buffered result lost ----
        offer(0, 4'd3, 32'h3333);
        tick();
        offer(0, 4'd4, 32'h4444);
        tick();
        idle(0);
        chk_bc("rmid_pre", 1'b1, 4'd3, 32'h3333, 2'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("rmid.BCEN_async", {31'd0, bus.BCEN}, 32'd0);
        chk("rmid.drop_err", {31'd0, bus.drop_err}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk_bc("rmid_e1", 1'b0, 4'd0, 32'd0, 2'd0);
        tick();
        chk_bc("rmid_e2", 1'b0, 4'd0, 32'd0, 2'd0);
        chk("rmid.src_ready", {29'd0, bus.src_ready}, 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
